nr_divider: RTL and testbench

Sequential signed integer divider using radix-2 non-restoring division. It is the inverse counterpart of the Booth multiplier and uses the same Request/Done handshake and N_BIT width.
Both operands are taken in a single Request. The block iterates one quotient bit per clock and presents a registered quotient and remainder when Done returns high.
It sits beside the multiplier in the arithmetic unit and is driven by the same sequencer.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_control.sv | 58 +++++
 rtl/nr_divider.sv | 77 +++++++
 tb/tb_nr_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, state encoding and two's complement helpers for nr_divider
`ifndef N_BIT
`define N_BIT 8
`endif

package div_pkg;

    localparam int N_BIT = `N_BIT;
    localparam int CNT_W = $clog2(N_BIT + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic [N_BIT-1:0] neg_n(input logic [N_BIT-1:0] x);
        return (~x) + N_BIT'(1);
    endfunction

    // The most-negative value maps onto itself, which reads correctly as an unsigned magnitude.
    function automatic logic [N_BIT-1:0] abs_n(input logic [N_BIT-1:0] x);
        return x[N_BIT-1] ? neg_n(x) : x;
    endfunction

endpackage

// File: rtl/div_control.sv
// rtl/div_control.sv - sequencing FSM and iteration counter for nr_divider
module div_control
    import div_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic Request,
    output logic load_s,
    output logic step_s,
    output logic fix_s,
    output logic Done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        fix_s   = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                Done = 1'b1;
                if (Request) begin
                    load_s  = 1'b1;
                    cnt_d   = CNT_W'(N_BIT);
                    state_d = CALC;
                end
            end
            CALC: begin
                step_s = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                fix_s   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/nr_divider.sv
// rtl/nr_divider.sv - sequential signed radix-2 non-restoring divider, one quotient bit per clock
module nr_divider
    import div_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Request,
    input  logic [N_BIT-1:0] Dividend,
    input  logic [N_BIT-1:0] Divisor,
    output logic             Done,
    output logic [N_BIT-1:0] Quotient,
    output logic [N_BIT-1:0] Remainder,
    output logic             DivZero,
    output logic             Overflow
);

    logic             load_s, step_s, fix_s;
    logic [N_BIT:0]   p_q, p_shift, p_step, p_fix, m_ext;
    logic [N_BIT-1:0] a_q, m_q;
    logic             sign_n_q, sign_d_q, dz_q, ov_q;

    div_control u_control (
        .Clock   (Clock),
        .Reset   (Reset),
        .Request (Request),
        .load_s  (load_s),
        .step_s  (step_s),
        .fix_s   (fix_s),
        .Done    (Done)
    );

    // P stays within [-M, M), so 2P+bit always fits in N_BIT+1 bits without losing P's top bit.
    always_comb begin
        m_ext   = {1'b0, m_q};
        p_shift = {p_q[N_BIT-1:0], a_q[N_BIT-1]};
        p_step  = p_q[N_BIT] ? (p_shift + m_ext) : (p_shift - m_ext);
        p_fix   = p_q[N_BIT] ? (p_q + m_ext) : p_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            p_q       <= '0;
            a_q       <= '0;
            m_q       <= '0;
            sign_n_q  <= 1'b0;
            sign_d_q  <= 1'b0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
            Overflow  <= 1'b0;
        end else if (load_s) begin
            p_q      <= '0;
            a_q      <= abs_n(Dividend);
            m_q      <= abs_n(Divisor);
            sign_n_q <= Dividend[N_BIT-1];
            sign_d_q <= Divisor[N_BIT-1];
            dz_q     <= (Divisor == '0);
            ov_q     <= (Dividend == {1'b1, {(N_BIT-1){1'b0}}}) && (Divisor == '1);
        end else if (step_s) begin
            p_q <= p_step;
            a_q <= {a_q[N_BIT-2:0], ~p_step[N_BIT]};
        end else if (fix_s) begin
            // With a zero divisor the remainder path already yields the dividend; only Q needs forcing.
            if (dz_q) begin
                Quotient <= '1;
            end else begin
                Quotient <= (sign_n_q ^ sign_d_q) ? neg_n(a_q) : a_q;
            end
            Remainder <= sign_n_q ? neg_n(p_fix[N_BIT-1:0]) : p_fix[N_BIT-1:0];
            DivZero   <= dz_q;
            Overflow  <= ov_q;
        end
    end

endmodule

// File: tb/tb_nr_divider.sv
// tb/tb_nr_divider.sv - randomized and directed self-checking bench for nr_divider
module tb_nr_divider;

    logic       Clock;
    logic       Reset;
    logic       Request;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic       Done;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       DivZero;
    logic       Overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    logic [7:0] last_q = 8'h00;

    logic [7:0] dir_a [10] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'd127, 8'd0, 8'd5, 8'd9};
    logic [7:0] dir_b [10] = '{8'd7,   8'd7,  8'hF9,  8'hF9, 8'hFF, 8'd1,  8'd127, 8'd5, 8'd0, 8'd3};

    nr_divider u_dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Request   (Request),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero),
        .Overflow  (Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic dz, output logic ov);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else if (sa == -128 && sb == -1) begin
            q  = 8'h80;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 8'(sa / sb);
            r = 8'(sa % sb);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inject, input string tag);
        logic [7:0] eq, er;
        logic       edz, eov;
        int         n;
        ref_div(a, b, eq, er, edz, eov);
        n = 0;
        while (!Done && n < 100) begin
            @(negedge Clock);
            n++;
        end
        Dividend = a;
        Divisor  = b;
        Request  = 1'b1;
        @(negedge Clock);
        Request = 1'b0;
        check_eq({tag, "_hold_q"}, Quotient, last_q);
        n = 0;
        while (!Done && n < 50) begin
            n++;
            if (n == inject) begin
                Request  = 1'b1;
                Dividend = 8'd20;
                Divisor  = 8'd3;
            end else begin
                Request = 1'b0;
            end
            @(negedge Clock);
        end
        Request = 1'b0;
        check_eq({tag, "_latency"}, n, 9);
        check_eq({tag, "_q"}, Quotient, eq);
        check_eq({tag, "_r"}, Remainder, er);
        check_eq({tag, "_dz"}, DivZero, edz);
        check_eq({tag, "_ov"}, Overflow, eov);
        last_q = eq;
    endtask

    initial begin
        Reset    = 1'b1;
        Request  = 1'b0;
        Dividend = 8'h00;
        Divisor  = 8'h00;
        repeat (2) @(negedge Clock);
        check_eq("rst_done", Done, 1);
        check_eq("rst_q", Quotient, 0);
        check_eq("rst_r", Remainder, 0);
        check_eq("rst_dz", DivZero, 0);
        check_eq("rst_ov", Overflow, 0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 10; i++) begin
            run_op(dir_a[i], dir_b[i], 0, $sformatf("dir%0d", i));
        end

        run_op(8'd100, 8'd7, 3, "inject");

        Dividend = 8'd100;
        Divisor  = 8'd7;
        Request  = 1'b1;
        @(negedge Clock);
        Request = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check_eq("midrst_done", Done, 1);
        check_eq("midrst_q", Quotient, 0);
        check_eq("midrst_r", Remainder, 0);
        check_eq("midrst_dz", DivZero, 0);
        check_eq("midrst_ov", Overflow, 0);
        last_q = 8'h00;

        run_op(8'd50, 8'd6, 0, "after_rst");

        Dividend = 8'd50;
        Divisor  = 8'd6;
        Request  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clock);
            lat = 0;
            while (!Done && lat < 50) begin
                lat++;
                @(negedge Clock);
            end
            check_eq($sformatf("b2b%0d_latency", k), lat, 9);
            check_eq($sformatf("b2b%0d_q", k), Quotient, 8'd8);
            check_eq($sformatf("b2b%0d_r", k), Remainder, 8'd2);
        end
        Request = 1'b0;
        last_q  = 8'd8;

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(ra, rb, 0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
